// File: rtl/qracc_pkg.sv
// Shared types and constants for the QR-array bit-serial MAC sequencer.
// Holds the FSM state encoding and the idle values for selects and ADC phases.
package qracc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      EVAL,
      SAMPLE,
      DONE
   } mac_seq_state_t;

   // ADC phase controls, driven as a group; complements are generated in the wrapper.
   typedef struct packed {
      logic nf;
      logic r2a;
      logic m2a;
   } phase_t;

   localparam phase_t PHASE_IDLE = '{nf: 1'b0, r2a: 1'b0, m2a: 1'b1};
   localparam phase_t PHASE_EVAL = '{nf: 1'b1, r2a: 1'b1, m2a: 1'b0};

   localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/qracc_therm_decoder.sv
// Per-column thermometer decoder: highest set comparator gives a signed code
// centred on zero; any clear comparator below it flags a bubble.
module qracc_therm_decoder #(
   parameter int numAdcBits = 4,
   parameter int compCount  = 2**numAdcBits - 1
) (
   input  logic [compCount-1:0]         therm,
   output logic signed [numAdcBits-1:0] enc,
   output logic                         bubble
);

   localparam logic [numAdcBits-1:0] HALF = numAdcBits'(1) << (numAdcBits - 1);

   logic [numAdcBits-1:0] level;

   // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
   always_comb begin
      level = '0;
      for (int i = 0; i < compCount; i++) begin
         if (therm[i]) level = numAdcBits'(i + 1);
      end
      bubble = 1'b0;
      for (int i = 0; i < compCount; i++) begin
         if ((i < int'(level)) && !therm[i]) bubble = 1'b1;
      end
      // level - 2**(numAdcBits-1) modulo 2**numAdcBits is just an MSB flip.
      enc = $signed(level ^ HALF);
   end

endmodule

// File: rtl/qracc_mac_seq.sv
// Bit-serial MAC sequencer: drives the PSM/NSM switch matrix one activation plane at a time
// (MSB first), then shift-accumulates the decoded ADC codes per column into a signed result.
module qracc_mac_seq
   import qracc_pkg::*;
#(
   parameter int numRows    = 128,
   parameter int numCols    = 32,
   parameter int numAdcBits = 4,
   parameter int maxInBits  = 8,
   parameter int accBits    = numAdcBits + maxInBits
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          cfg_binary_i,
   input  logic                                          cfg_signed_i,
   input  logic [$clog2(maxInBits+1)-1:0]                cfg_n_bits_i,
   input  logic [maxInBits*numRows-1:0]                  act_p_i,
   input  logic [maxInBits*numRows-1:0]                  act_n_i,
   input  logic                                          act_valid_i,
   output logic                                          act_ready_o,
   input  logic [numCols*(2**numAdcBits-1)-1:0]          adc_therm_i,
   output logic [numRows-1:0]                            psm_vdr_sel_o,
   output logic [numRows-1:0]                            psm_vss_sel_o,
   output logic [numRows-1:0]                            psm_vrst_sel_o,
   output logic [numRows-1:0]                            nsm_vdr_sel_o,
   output logic [numRows-1:0]                            nsm_vss_sel_o,
   output logic [numRows-1:0]                            nsm_vrst_sel_o,
   output logic                                          nf_o,
   output logic                                          r2a_o,
   output logic                                          m2a_o,
   output logic [numCols*accBits-1:0]                    acc_o,
   output logic                                          acc_valid_o,
   input  logic                                          acc_ready_i,
   output logic                                          busy_o,
   output logic [15:0]                                   bubble_cnt_o
);

   localparam int compCount = 2**numAdcBits - 1;
   localparam int NBW       = $clog2(maxInBits + 1);
   localparam int KW        = clog2_min1(maxInBits);
   localparam int PW        = maxInBits * numRows;

   mac_seq_state_t              state;
   logic [PW-1:0]               act_p, act_n;
   logic                        binary, signed_mode, neg, pend;
   logic [KW-1:0]               k, msb;
   logic [numCols*compCount-1:0] therm;

   logic [NBW-1:0]              n_req;
   logic [KW-1:0]               k_first, k_next;
   logic [numRows-1:0]          drv_p, drv_n;
   logic                        drv_binary;
   logic [numRows-1:0]          d_pvdr, d_pvss, d_pvrst, d_nvdr, d_nvss, d_nvrst;

   logic signed [numAdcBits-1:0] enc [numCols];
   logic [numCols-1:0]           bub;
   logic [numCols*accBits-1:0]   acc_next;

   // Selects for the plane about to be driven: the first plane at accept, the next one after SAMPLE.
   always_comb begin
      n_req = cfg_n_bits_i;
      if (n_req == '0) n_req = NBW'(1);
      else if (n_req > NBW'(maxInBits)) n_req = NBW'(maxInBits);
      k_first = KW'(n_req - NBW'(1));
      k_next  = k - KW'(1);
      if (state == IDLE) begin
         drv_p      = act_p_i[k_first*numRows +: numRows];
         drv_n      = act_n_i[k_first*numRows +: numRows];
         drv_binary = cfg_binary_i;
      end else begin
         drv_p      = act_p[k_next*numRows +: numRows];
         drv_n      = act_n[k_next*numRows +: numRows];
         drv_binary = binary;
      end
      d_pvdr  = drv_p & ~drv_n;
      d_pvss  = drv_n & ~drv_p;
      d_pvrst = ~drv_p & ~drv_n;
      d_nvdr  = drv_binary ? '0 : d_pvss;
      d_nvss  = drv_binary ? '0 : d_pvdr;
      d_nvrst = drv_binary ? '1 : d_pvrst;
   end

   for (genvar c = 0; c < numCols; c++) begin : g_col
      qracc_therm_decoder #(.numAdcBits(numAdcBits)) u_dec (
         .therm  (therm[c*compCount +: compCount]),
         .enc    (enc[c]),
         .bubble (bub[c])
      );
   end

   always_comb begin
      acc_next = acc_o;
      for (int c = 0; c < numCols; c++) begin
         acc_next[c*accBits +: accBits] = (acc_o[c*accBits +: accBits] << 1)
            + (neg ? -accBits'(enc[c]) : accBits'(enc[c]));
      end
   end

   // NOTE: operand and capture registers carry no reset; each is written before it is read.
   always_ff @(posedge clk) begin
      if (state == IDLE && act_valid_i && act_ready_o) begin
         act_p       <= act_p_i;
         act_n       <= act_n_i;
         binary      <= cfg_binary_i;
         signed_mode <= cfg_signed_i;
         msb         <= k_first;
      end
      if (state == SAMPLE) begin
         therm <= adc_therm_i;
         neg   <= signed_mode && (k == msb);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         k              <= '0;
         pend           <= 1'b0;
         psm_vdr_sel_o  <= '0;
         psm_vss_sel_o  <= '0;
         psm_vrst_sel_o <= '1;
         nsm_vdr_sel_o  <= '0;
         nsm_vss_sel_o  <= '0;
         nsm_vrst_sel_o <= '1;
         {nf_o, r2a_o, m2a_o} <= PHASE_IDLE;
         acc_o          <= '0;
         acc_valid_o    <= 1'b0;
         bubble_cnt_o   <= '0;
         act_ready_o    <= 1'b1;
         busy_o         <= 1'b0;
      end else begin
         // The plane captured in SAMPLE is folded in one cycle later, from registered comparator data.
         if (pend) begin
            pend  <= 1'b0;
            acc_o <= acc_next;
            if (|bub && bubble_cnt_o != BUBBLE_MAX) bubble_cnt_o <= bubble_cnt_o + 16'd1;
         end
         case (state)
            IDLE: begin
               if (act_valid_i && act_ready_o) begin
                  state          <= DRIVE;
                  k              <= k_first;
                  acc_o          <= '0;
                  act_ready_o    <= 1'b0;
                  busy_o         <= 1'b1;
                  psm_vdr_sel_o  <= d_pvdr;
                  psm_vss_sel_o  <= d_pvss;
                  psm_vrst_sel_o <= d_pvrst;
                  nsm_vdr_sel_o  <= d_nvdr;
                  nsm_vss_sel_o  <= d_nvss;
                  nsm_vrst_sel_o <= d_nvrst;
               end
            end
            DRIVE: begin
               state          <= EVAL;
               psm_vdr_sel_o  <= '0;
               psm_vss_sel_o  <= '0;
               psm_vrst_sel_o <= '1;
               nsm_vdr_sel_o  <= '0;
               nsm_vss_sel_o  <= '0;
               nsm_vrst_sel_o <= '1;
               {nf_o, r2a_o, m2a_o} <= PHASE_EVAL;
            end
            EVAL: begin
               state <= SAMPLE;
               {nf_o, r2a_o, m2a_o} <= PHASE_IDLE;
            end
            SAMPLE: begin
               pend <= 1'b1;
               if (k == '0) begin
                  state <= DONE;
               end else begin
                  state          <= DRIVE;
                  k              <= k_next;
                  psm_vdr_sel_o  <= d_pvdr;
                  psm_vss_sel_o  <= d_pvss;
                  psm_vrst_sel_o <= d_pvrst;
                  nsm_vdr_sel_o  <= d_nvdr;
                  nsm_vss_sel_o  <= d_nvss;
                  nsm_vrst_sel_o <= d_nvrst;
               end
            end
            DONE: begin
               if (acc_valid_o && acc_ready_i) begin
                  state       <= IDLE;
                  acc_valid_o <= 1'b0;
                  act_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
               end else begin
                  acc_valid_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
